// File: rtl/mac_pipe_if.sv
// rtl/mac_pipe_if.sv - operand stream and result bundle for the mac_pipe processing element
interface mac_pipe_if #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 10,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] x;
    logic              first;
    logic              last;
    logic              out_valid;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_ovf;
    logic [ACC_W-1:0]  acc_run;

    modport master (
        output in_valid, w, x, first, last,
        input  out_valid, out_acc, out_cnt, out_ovf, acc_run
    );

    modport slave (
        input  in_valid, w, x, first, last,
        output out_valid, out_acc, out_cnt, out_ovf, acc_run
    );
endinterface

// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - 3-stage multiply-accumulate element with first/last framing and clamp/wrap
module mac_pipe #(
    parameter int DATA_W   = 4,
    parameter int ACC_W    = 10,
    parameter int CNT_W    = 8,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    mac_pipe_if.slave  bus
);
    localparam int PW = 2 * DATA_W;
    localparam int EW = ACC_W + 1;

    generate
        if (ACC_W < 2 * DATA_W) begin : g_width_check
            $error("mac_pipe: ACC_W must be at least 2*DATA_W");
        end
    endgenerate

    logic              s1_v_q, s1_v_d;
    logic [DATA_W-1:0] s1_w_q, s1_w_d;
    logic [DATA_W-1:0] s1_x_q, s1_x_d;
    logic              s1_first_q, s1_first_d;
    logic              s1_last_q, s1_last_d;

    logic              s2_v_q, s2_v_d;
    logic [PW-1:0]     s2_p_q, s2_p_d;
    logic              s2_first_q, s2_first_d;
    logic              s2_last_q, s2_last_d;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_acc_q, out_acc_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              out_ovf_q, out_ovf_d;

    logic [PW-1:0]     w_ext, x_ext, product;
    logic [EW-1:0]     p_ext, acc_ext, sum;
    logic              out_of_range;
    logic [ACC_W-1:0]  acc_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              ovf_next;

    always_comb begin
        s1_v_d     = bus.in_valid;
        s1_w_d     = s1_w_q;
        s1_x_d     = s1_x_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        if (bus.in_valid) begin
            s1_w_d     = bus.w;
            s1_x_d     = bus.x;
            s1_first_d = bus.first;
            s1_last_d  = bus.last;
        end

        // Extending both operands to PW bits makes the truncated product correct in either mode
        if (SIGNED != 0) begin
            w_ext = {{DATA_W{s1_w_q[DATA_W-1]}}, s1_w_q};
            x_ext = {{DATA_W{s1_x_q[DATA_W-1]}}, s1_x_q};
        end else begin
            w_ext = {{DATA_W{1'b0}}, s1_w_q};
            x_ext = {{DATA_W{1'b0}}, s1_x_q};
        end
        product    = w_ext * x_ext;
        s2_v_d     = s1_v_q;
        s2_p_d     = s1_v_q ? product : s2_p_q;
        s2_first_d = s1_first_q;
        s2_last_d  = s1_last_q;

        if (SIGNED != 0) begin
            p_ext   = {{(EW-PW){s2_p_q[PW-1]}}, s2_p_q};
            acc_ext = {acc_q[ACC_W-1], acc_q};
        end else begin
            p_ext   = {{(EW-PW){1'b0}}, s2_p_q};
            acc_ext = {1'b0, acc_q};
        end
        sum = (s2_first_q ? '0 : acc_ext) + p_ext;

        // One guard bit suffices: |acc| and |p| each fit ACC_W, so the sum fits ACC_W+1
        if (SIGNED != 0) begin
            out_of_range = sum[EW-1] ^ sum[EW-2];
        end else begin
            out_of_range = sum[EW-1];
        end

        acc_next = sum[ACC_W-1:0];
        if (out_of_range && (SATURATE != 0)) begin
            if (SIGNED == 0) begin
                acc_next = '1;
            end else if (sum[EW-1]) begin
                acc_next = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                acc_next = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end

        if (s2_first_q) begin
            cnt_next = CNT_W'(1);
        end else if (cnt_q == '1) begin
            cnt_next = cnt_q;
        end else begin
            cnt_next = cnt_q + CNT_W'(1);
        end
        ovf_next = (s2_first_q ? 1'b0 : ovf_q) | out_of_range;

        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        out_acc_d   = out_acc_q;
        out_cnt_d   = out_cnt_q;
        out_ovf_d   = out_ovf_q;
        if (s2_v_q) begin
            acc_d = acc_next;
            cnt_d = cnt_next;
            ovf_d = ovf_next;
            if (s2_last_q) begin
                out_valid_d = 1'b1;
                out_acc_d   = acc_next;
                out_cnt_d   = cnt_next;
                out_ovf_d   = ovf_next;
            end
        end

        // Flush drops everything in flight but leaves the last published result visible
        if (clear) begin
            s1_v_d      = 1'b0;
            s2_v_d      = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
            out_acc_d   = out_acc_q;
            out_cnt_d   = out_cnt_q;
            out_ovf_d   = out_ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_w_q      <= '0;
            s1_x_q      <= '0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_v_q      <= 1'b0;
            s2_p_q      <= '0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_w_q      <= s1_w_d;
            s1_x_q      <= s1_x_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s2_v_q      <= s2_v_d;
            s2_p_q      <= s2_p_d;
            s2_first_q  <= s2_first_d;
            s2_last_q   <= s2_last_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_cnt_q   <= out_cnt_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_cnt   = out_cnt_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.acc_run   = acc_q;
endmodule

// File: tb/tb_mac_pipe.sv
// tb/tb_mac_pipe.sv - three mac_pipe configurations driven in lockstep against an arithmetic model
module tb_mac_pipe;
    localparam int DW    = 4;
    localparam int AW    = 10;
    localparam int CW    = 8;
    localparam int NCFG  = 3;
    localparam int MAXC  = 1024;
    localparam int AMASK = (1 << AW) - 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, clear, in_valid, first, last;
    logic [DW-1:0] w, x;

    mac_pipe_if #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW)) if_us ();
    mac_pipe_if #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW)) if_uw ();
    mac_pipe_if #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW)) if_ss ();

    assign if_us.in_valid = in_valid; assign if_us.w = w; assign if_us.x = x;
    assign if_us.first = first;       assign if_us.last = last;
    assign if_uw.in_valid = in_valid; assign if_uw.w = w; assign if_uw.x = x;
    assign if_uw.first = first;       assign if_uw.last = last;
    assign if_ss.in_valid = in_valid; assign if_ss.w = w; assign if_ss.x = x;
    assign if_ss.first = first;       assign if_ss.last = last;

    mac_pipe #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW), .SIGNED(0), .SATURATE(1))
        u_us (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_us.slave));
    mac_pipe #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW), .SIGNED(0), .SATURATE(0))
        u_uw (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_uw.slave));
    mac_pipe #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW), .SIGNED(1), .SATURATE(1))
        u_ss (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_ss.slave));

    bit cfg_signed [NCFG] = '{1'b0, 1'b0, 1'b1};
    bit cfg_sat    [NCFG] = '{1'b1, 1'b0, 1'b1};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit started  = 1'b0;

    // Model state: running dot product per configuration and the published result
    int macc [NCFG];
    int mcnt [NCFG];
    bit movf [NCFG];
    bit ev;
    int eacc [NCFG];
    int ecnt [NCFG];
    bit eovf [NCFG];

    bit          hv [MAXC];
    bit          hf [MAXC];
    bit          hl [MAXC];
    bit          kill [MAXC];
    logic [DW-1:0] hw [MAXC];
    logic [DW-1:0] hx [MAXC];

    task automatic chk(string name, int c, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cfg=%0d cycle=%0d actual=%0d required=%0d", name, c, cyc, act, exp);
        end
    endtask

    function automatic int opval(logic [DW-1:0] v, bit sgn);
        if (sgn && v[DW-1]) return int'(v) - (1 << DW);
        return int'(v);
    endfunction

    function automatic int fit(int s, bit sgn, bit sat, output bit oor);
        int lo, hi, r;
        lo  = sgn ? -(1 << (AW - 1)) : 0;
        hi  = sgn ? (1 << (AW - 1)) - 1 : (1 << AW) - 1;
        oor = (s < lo) || (s > hi);
        if (!oor) return s;
        if (sat) return (s < lo) ? lo : hi;
        r = ((s % (1 << AW)) + (1 << AW)) % (1 << AW);
        if (sgn && r > hi) r = r - (1 << AW);
        return r;
    endfunction

    // A term presented in cycle t lands at the end of t+2 unless a reset/clear hit t..t+2
    initial begin
        forever begin
            @(posedge clk);
            if (cyc >= MAXC) begin
                $display("FAIL model_history cfg=0 cycle=%0d actual=%0d required=%0d", cyc, cyc, MAXC - 1);
                $fatal(1);
            end
            hv[cyc] = in_valid; hw[cyc] = w; hx[cyc] = x; hf[cyc] = first; hl[cyc] = last;
            kill[cyc] = !rst_n || clear;
            ev = 1'b0;
            for (int c = 0; c < NCFG; c++) begin
                if (!rst_n) begin
                    macc[c] = 0; mcnt[c] = 0; movf[c] = 1'b0;
                    eacc[c] = 0; ecnt[c] = 0; eovf[c] = 1'b0;
                end else if (clear) begin
                    macc[c] = 0; mcnt[c] = 0; movf[c] = 1'b0;
                end else if (cyc >= 2 && hv[cyc-2] && !kill[cyc-2] && !kill[cyc-1]) begin
                    int prod, base;
                    bit oor;
                    prod = opval(hw[cyc-2], cfg_signed[c]) * opval(hx[cyc-2], cfg_signed[c]);
                    base = hf[cyc-2] ? 0 : macc[c];
                    macc[c] = fit(base + prod, cfg_signed[c], cfg_sat[c], oor);
                    movf[c] = (hf[cyc-2] ? 1'b0 : movf[c]) | oor;
                    mcnt[c] = hf[cyc-2] ? 1 : ((mcnt[c] < CMAX) ? mcnt[c] + 1 : CMAX);
                    if (hl[cyc-2]) begin
                        ev = 1'b1;
                        eacc[c] = macc[c]; ecnt[c] = mcnt[c]; eovf[c] = movf[c];
                    end
                end
            end
            cyc++;
            started = 1'b1;
        end
    end

    task automatic check_dut(int c, logic ov, logic [AW-1:0] oa, logic [CW-1:0] oc,
                             logic oo, logic [AW-1:0] ar);
        chk("out_valid", c, int'(ov), int'(ev));
        chk("out_acc",   c, int'(oa), eacc[c] & AMASK);
        chk("out_cnt",   c, int'(oc), ecnt[c]);
        chk("out_ovf",   c, int'(oo), int'(eovf[c]));
        chk("acc_run",   c, int'(ar), macc[c] & AMASK);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check_dut(0, if_us.out_valid, if_us.out_acc, if_us.out_cnt, if_us.out_ovf, if_us.acc_run);
                check_dut(1, if_uw.out_valid, if_uw.out_acc, if_uw.out_cnt, if_uw.out_ovf, if_uw.acc_run);
                check_dut(2, if_ss.out_valid, if_ss.out_acc, if_ss.out_cnt, if_ss.out_ovf, if_ss.acc_run);
            end
        end
    end

    task automatic drive(bit v, logic [DW-1:0] wv, logic [DW-1:0] xv, bit f, bit l);
        @(posedge clk);
        #1;
        in_valid = v; w = wv; x = xv; first = f; last = l;
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic pin(string name, int c, logic ov, logic [AW-1:0] oa, logic [CW-1:0] oc,
                       logic oo, int ea, int ec, bit eo);
        chk({name, "_valid"},     c, int'(ov), 1);
        chk({name, "_acc"},       c, int'(oa), ea & AMASK);
        chk({name, "_cnt"},       c, int'(oc), ec);
        chk({name, "_ovf"},       c, int'(oo), int'(eo));
        chk({name, "_model_acc"}, c, eacc[c] & AMASK, ea & AMASK);
        chk({name, "_model_cnt"}, c, ecnt[c], ec);
    endtask

    task automatic pin3(string name, int a0, int c0, bit o0, int a1, int c1, bit o1,
                        int a2, int c2, bit o2);
        @(negedge clk);
        pin(name, 0, if_us.out_valid, if_us.out_acc, if_us.out_cnt, if_us.out_ovf, a0, c0, o0);
        pin(name, 1, if_uw.out_valid, if_uw.out_acc, if_uw.out_cnt, if_uw.out_ovf, a1, c1, o1);
        pin(name, 2, if_ss.out_valid, if_ss.out_acc, if_ss.out_cnt, if_ss.out_ovf, a2, c2, o2);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        in_valid = 1'b0; w = '0; x = '0; first = 1'b0; last = 1'b0;

        repeat (2) drive(1'b1, 4'd3, 4'd3, 1'b1, 1'b1);
        @(negedge clk);
        chk("rst_out_valid", 0, int'(if_us.out_valid), 0);
        chk("rst_out_acc",   0, int'(if_us.out_acc), 0);
        chk("rst_acc_run",   2, int'(if_ss.acc_run), 0);
        @(posedge clk);
        #1 rst_n = 1'b1; in_valid = 1'b0;
        idle(4);

        drive(1'b1, 4'd15, 4'd15, 1'b1, 1'b0);
        drive(1'b1, 4'd15, 4'd15, 1'b0, 1'b0);
        drive(1'b1, 4'd15, 4'd15, 1'b0, 1'b1);
        idle(3);
        pin3("dot3", 675, 3, 1'b0, 675, 3, 1'b0, 3, 3, 1'b0);

        drive(1'b1, 4'd15, 4'd15, 1'b1, 1'b0);
        repeat (3) drive(1'b1, 4'd15, 4'd15, 1'b0, 1'b0);
        drive(1'b1, 4'd15, 4'd15, 1'b0, 1'b1);
        idle(3);
        pin3("sat5", 1023, 5, 1'b1, 101, 5, 1'b1, 5, 5, 1'b0);

        drive(1'b1, 4'h8, 4'h7, 1'b1, 1'b0);
        drive(1'b1, 4'h3, 4'hE, 1'b0, 1'b1);
        idle(3);
        pin3("signed2", 98, 2, 1'b0, 98, 2, 1'b0, -62, 2, 1'b0);

        drive(1'b1, 4'h8, 4'h7, 1'b1, 1'b0);
        repeat (8) drive(1'b1, 4'h8, 4'h7, 1'b0, 1'b0);
        drive(1'b1, 4'h8, 4'h7, 1'b0, 1'b1);
        idle(3);
        pin3("negclamp", 560, 10, 1'b0, 560, 10, 1'b0, -512, 10, 1'b1);

        drive(1'b1, 4'd2, 4'd3, 1'b1, 1'b1);
        drive(1'b1, 4'd4, 4'd4, 1'b1, 1'b0);
        drive(1'b0, 4'd9, 4'd9, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 4'd1, 1'b0, 1'b1);
        pin3("b2b_a", 6, 1, 1'b0, 6, 1, 1'b0, 6, 1, 1'b0);
        idle(3);
        pin3("b2b_b", 17, 2, 1'b0, 17, 2, 1'b0, 17, 2, 1'b0);

        drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b0);
        drive(1'b1, 4'd1, 4'd2, 1'b0, 1'b0);
        @(posedge clk);
        #1 clear = 1'b1; in_valid = 1'b1; w = 4'd1; x = 4'd2; first = 1'b0; last = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0; in_valid = 1'b0;
        idle(3);
        @(negedge clk);
        chk("clr_out_valid", 0, int'(if_us.out_valid), 0);
        chk("clr_acc_run",   0, int'(if_us.acc_run), 0);
        chk("clr_held_acc",  0, int'(if_us.out_acc), 17);
        chk("clr_held_cnt",  2, int'(if_ss.out_cnt), 2);

        drive(1'b1, 4'd5, 4'd5, 1'b1, 1'b1);
        idle(3);
        pin3("after_clr", 25, 1, 1'b0, 25, 1, 1'b0, 25, 1, 1'b0);

        @(posedge clk);
        #1 clear = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1 clear = 1'b0;
        drive(1'b1, 4'd2, 4'd2, 1'b0, 1'b1);
        idle(3);
        pin3("nofirst", 4, 1, 1'b0, 4, 1, 1'b0, 4, 1, 1'b0);

        drive(1'b1, 4'd0, 4'd1, 1'b1, 1'b0);
        repeat (258) drive(1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
        drive(1'b1, 4'd0, 4'd1, 1'b0, 1'b1);
        idle(3);
        pin3("cntsat", 0, 255, 1'b0, 0, 255, 1'b0, 0, 255, 1'b0);

        idle(3);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
